// File: rtl/vetores_pkg.sv
// Shared definitions for the vector-operation response checker.
//   - estado_t      : checker FSM state encoding
//   - LARGURA_PADRAO: default operand width
//   - modelo_ouro() : golden model {or, logical or, not} for the default
//                     width, kept here so benches can reuse it
package vetores_pkg;

    localparam int LARGURA_PADRAO = 3;
    localparam int LARGURA_OURO   = 3 * LARGURA_PADRAO + 1;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        EXECUTANDO = 2'd1,
        DRENANDO   = 2'd2,
        CONCLUIDO  = 2'd3
    } estado_t;

    // Packed as {a|b, (|a)||(|b), ~{a,b}}; a sits in the MSBs of the NOT field.
    function automatic logic [LARGURA_OURO-1:0] modelo_ouro(
        input logic [LARGURA_PADRAO-1:0] a,
        input logic [LARGURA_PADRAO-1:0] b
    );
        return {a | b, (|a) || (|b), ~{a, b}};
    endfunction

endpackage

// File: rtl/checar_vetores_modelo.sv
// Combinational golden model of the vector-operation block.
// Ports:
//   a, b     : operands (LARGURA bits each)
//   esp_or   : expected bitwise OR
//   esp_log  : expected logical OR
//   esp_not  : expected NOT of {a,b}, a in the MSBs
module modelo_vetores #(
    parameter int LARGURA = 3
) (
    input  logic [LARGURA-1:0]   a,
    input  logic [LARGURA-1:0]   b,
    output logic [LARGURA-1:0]   esp_or,
    output logic                 esp_log,
    output logic [2*LARGURA-1:0] esp_not
);

    generate
        for (genvar gi = 0; gi < LARGURA; gi++) begin : g_bit
            assign esp_or[gi]              = a[gi] | b[gi];
            assign esp_not[gi]             = ~b[gi];
            assign esp_not[gi + LARGURA]   = ~a[gi];
        end
    endgenerate

    assign esp_log = (|a) || (|b);

endmodule

// File: rtl/checar_vetores.sv
// Sequential response checker: accepts operand pairs with the observed
// outputs of the vector-operation block, compares them one cycle later
// against the golden model and keeps pass/fail statistics for a run of
// N_VETORES vectors.
// Ports:
//   clk, rst           : clock (rising edge), async active-high reset
//   iniciar            : start pulse (honoured in OCIOSO / CONCLUIDO)
//   valido / pronto    : vector handshake, transfer on valido && pronto
//   a, b               : operands
//   obs_*              : observed outputs of the block under test
//   cont_ok, cont_erro : saturating pass/fail counters for the run
//   idx_primeiro_erro  : index of the first mismatching vector
//   houve_erro         : at least one mismatch this run
//   erro_vetor         : one-cycle pulse after a mismatching compare
//   concluido          : run finished, held until next iniciar or reset
module checar_vetores
    import vetores_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int N_VETORES    = 4,
    parameter int LARGURA_CONT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iniciar,
    input  logic                    valido,
    output logic                    pronto,
    input  logic [LARGURA-1:0]      a,
    input  logic [LARGURA-1:0]      b,
    input  logic [LARGURA-1:0]      obs_or_bit_a_bit,
    input  logic                    obs_or_logico,
    input  logic [2*LARGURA-1:0]    obs_not,
    output logic [LARGURA_CONT-1:0] cont_ok,
    output logic [LARGURA_CONT-1:0] cont_erro,
    output logic [LARGURA_CONT-1:0] idx_primeiro_erro,
    output logic                    houve_erro,
    output logic                    erro_vetor,
    output logic                    concluido
);

    // Run-length counter is sized from N_VETORES alone so a narrow
    // LARGURA_CONT (which saturates) can never stall the end-of-run detect.
    localparam int                    LARG_RUN = (N_VETORES > 1) ? $clog2(N_VETORES) : 1;
    localparam logic [LARG_RUN-1:0]     ULTIMO   = LARG_RUN'(N_VETORES - 1);
    localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;

    estado_t estado_q, estado_d;

    logic [LARG_RUN-1:0]     run_q;
    logic [LARGURA_CONT-1:0] idx_q;

    // Stage 1 registers
    logic                    s1_valido_q;
    logic [LARGURA-1:0]      s1_a_q;
    logic [LARGURA-1:0]      s1_b_q;
    logic [LARGURA-1:0]      s1_obs_or_q;
    logic                    s1_obs_log_q;
    logic [2*LARGURA-1:0]    s1_obs_not_q;
    logic [LARGURA_CONT-1:0] s1_idx_q;

    // Stage 2 results
    logic [LARGURA_CONT-1:0] cont_ok_q;
    logic [LARGURA_CONT-1:0] cont_erro_q;
    logic [LARGURA_CONT-1:0] idx_erro_q;
    logic                    houve_erro_q;
    logic                    erro_vetor_q;

    logic [LARGURA-1:0]      esp_or;
    logic                    esp_log;
    logic [2*LARGURA-1:0]    esp_not;
    logic                    confere;

    logic transfer;
    logic ultimo_aceito;
    logic limpar;

    assign pronto        = (estado_q == EXECUTANDO);
    assign concluido     = (estado_q == CONCLUIDO);
    assign transfer      = valido && pronto;
    assign ultimo_aceito = transfer && (run_q == ULTIMO);
    assign limpar        = iniciar && ((estado_q == OCIOSO) || (estado_q == CONCLUIDO));

    // ---------------------------------------------------------------- FSM
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:     if (iniciar)       estado_d = EXECUTANDO;
            EXECUTANDO: if (ultimo_aceito) estado_d = DRENANDO;
            // Leave only once the last vector has been compared
            DRENANDO:   if (!s1_valido_q)  estado_d = CONCLUIDO;
            CONCLUIDO:  if (iniciar)       estado_d = EXECUTANDO;
            default:                       estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // ------------------------------------------------ acceptance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
            idx_q <= '0;
        end else if (limpar) begin
            run_q <= '0;
            idx_q <= '0;
        end else if (transfer) begin
            run_q <= run_q + 1'b1;
            if (idx_q != CONT_MAX) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valido_q  <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_obs_or_q  <= '0;
            s1_obs_log_q <= 1'b0;
            s1_obs_not_q <= '0;
            s1_idx_q     <= '0;
        end else begin
            s1_valido_q <= transfer;
            if (transfer) begin
                s1_a_q       <= a;
                s1_b_q       <= b;
                s1_obs_or_q  <= obs_or_bit_a_bit;
                s1_obs_log_q <= obs_or_logico;
                s1_obs_not_q <= obs_not;
                s1_idx_q     <= idx_q;
            end
        end
    end

    // ------------------------------------------------------------ stage 2
    modelo_vetores #(
        .LARGURA (LARGURA)
    ) u_modelo (
        .a       (s1_a_q),
        .b       (s1_b_q),
        .esp_or  (esp_or),
        .esp_log (esp_log),
        .esp_not (esp_not)
    );

    assign confere = (s1_obs_or_q == esp_or)
                  && (s1_obs_log_q == esp_log)
                  && (s1_obs_not_q == esp_not);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_ok_q    <= '0;
            cont_erro_q  <= '0;
            idx_erro_q   <= '0;
            houve_erro_q <= 1'b0;
            erro_vetor_q <= 1'b0;
        end else begin
            erro_vetor_q <= s1_valido_q && !confere;
            // limpar and s1_valido_q never coincide: the pipe is empty
            // in the states where iniciar is honoured.
            if (limpar) begin
                cont_ok_q    <= '0;
                cont_erro_q  <= '0;
                idx_erro_q   <= '0;
                houve_erro_q <= 1'b0;
            end else if (s1_valido_q) begin
                if (confere) begin
                    if (cont_ok_q != CONT_MAX) begin
                        cont_ok_q <= cont_ok_q + 1'b1;
                    end
                end else begin
                    if (cont_erro_q != CONT_MAX) begin
                        cont_erro_q <= cont_erro_q + 1'b1;
                    end
                    if (!houve_erro_q) begin
                        houve_erro_q <= 1'b1;
                        idx_erro_q   <= s1_idx_q;
                    end
                end
            end
        end
    end

    assign cont_ok           = cont_ok_q;
    assign cont_erro         = cont_erro_q;
    assign idx_primeiro_erro = idx_erro_q;
    assign houve_erro        = houve_erro_q;
    assign erro_vetor        = erro_vetor_q;

endmodule
